mdu_hilo: RTL and testbench

- Multiply/divide unit with the architectural HI/LO register pair.
- Executes the MDU operations that the control unit encodes (MDUOp, MTHILO, MFHILO).
- Sits in the EX stage beside the ALU.
- Multi-cycle, with a busy output that the hazard unit uses to stall any MDU-class instruction in decode.

---
 rtl/mdu_hilo_pkg.sv | 38 +++
 rtl/mdu_hilo_if.sv | 24 ++
 rtl/mdu_divider.sv | 54 +++++
 rtl/mdu_hilo.sv | 129 ++++++++++++
 tb/tb_mdu_hilo.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/mdu_hilo_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, HI/LO select values, FSM states.
package mdu_hilo_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [3:0] MDU_DUM   = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MADD  = 4'd5;
  localparam logic [3:0] MDU_MADDU = 4'd6;
  localparam logic [3:0] MDU_MSUB  = 4'd7;
  localparam logic [3:0] MDU_MSUBU = 4'd8;

  localparam logic [1:0] MTHILO_NONE = 2'b00;
  localparam logic [1:0] MTHILO_LO   = 2'b01;
  localparam logic [1:0] MTHILO_HI   = 2'b11;

  localparam logic [1:0] MFHILO_NONE = 2'b00;
  localparam logic [1:0] MFHILO_LO   = 2'b01;
  localparam logic [1:0] MFHILO_HI   = 2'b10;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} mdu_state_e;

  function automatic logic op_legal(input logic [3:0] op);
    return (op >= MDU_MULT) && (op <= MDU_MSUBU);
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_mul_signed(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MADD) || (op == MDU_MSUB);
  endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// Control-side bundle of the MDU: op/select inputs, operands, flush, and busy/read-back outputs.
interface mdu_hilo_if;
  import mdu_hilo_pkg::*;

  logic [3:0]        mdu_op;
  logic [1:0]        mthilo;
  logic [1:0]        mfhilo;
  logic [WORD_W-1:0] rs_data;
  logic [WORD_W-1:0] rt_data;
  logic              flush;
  logic              busy;
  logic [WORD_W-1:0] hilo_out;

  modport master (
    output mdu_op, mthilo, mfhilo, rs_data, rt_data, flush,
    input  busy, hilo_out
  );

  modport slave (
    input  mdu_op, mthilo, mfhilo, rs_data, rt_data, flush,
    output busy, hilo_out
  );

endinterface

// File: rtl/mdu_divider.sv
// Iterative 32-bit unsigned restoring divider: one quotient bit per cycle, done after 32 steps.
module mdu_divider (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic        run_q;
  logic [5:0]  cnt_q;
  logic [31:0] quo_q, rem_q, dvs_q;
  logic [32:0] shifted, diff;
  logic        ge;

  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    // Partial remainder stays below 2*divisor, so the borrow bit alone decides the compare.
    ge      = ~diff[32];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (run_q) begin
      if (cnt_q == 6'd32) begin
        run_q <= 1'b0;
      end else begin
        rem_q <= ge ? diff[31:0] : shifted[31:0];
        quo_q <= {quo_q[30:0], ge};
        cnt_q <= cnt_q + 6'd1;
      end
    end
  end

  assign done      = run_q && (cnt_q == 6'd32);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mdu_hilo.sv
// EX-stage multiply/divide unit owning the HI/LO pair; multi-cycle with a busy stall output.
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int unsigned MULT_LAT = 5
) (
  input logic         clk,
  input logic         reset_n,
  mdu_hilo_if.slave   bus
);

  localparam logic [4:0] LatInit = 5'(MULT_LAT);

  mdu_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] a_q, b_q;
  logic [3:0]  op_q;

  logic        busy, start, div_start, div_done, sdiv;
  logic [31:0] dvd_mag, dvs_mag, quo, rem, div_lo, div_hi;
  logic [63:0] ext_a, ext_b, product, mul_res;

  assign busy  = (state_q != StIdle);
  assign start = op_legal(bus.mdu_op) && !busy && !bus.flush;

  // Divider always sees magnitudes; signs are restored from the latched operands.
  assign sdiv      = (bus.mdu_op == MDU_DIV);
  assign dvd_mag   = (sdiv && bus.rs_data[31]) ? -bus.rs_data : bus.rs_data;
  assign dvs_mag   = (sdiv && bus.rt_data[31]) ? -bus.rt_data : bus.rt_data;
  assign div_start = start && op_is_div(bus.mdu_op);

  mdu_divider u_divider (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (div_start),
    .dividend  (dvd_mag),
    .divisor   (dvs_mag),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem)
  );

  always_comb begin
    ext_a   = op_mul_signed(op_q) ? {{32{a_q[31]}}, a_q} : {32'h0, a_q};
    ext_b   = op_mul_signed(op_q) ? {{32{b_q[31]}}, b_q} : {32'h0, b_q};
    product = ext_a * ext_b;
    case (op_q)
      MDU_MADD, MDU_MADDU: mul_res = {hi_q, lo_q} + product;
      MDU_MSUB, MDU_MSUBU: mul_res = {hi_q, lo_q} - product;
      default:             mul_res = product;
    endcase
  end

  always_comb begin
    div_lo = quo;
    div_hi = rem;
    if (op_q == MDU_DIV) begin
      // A zero divisor is treated as opposite-signed, so DIV x/0 yields quotient 1.
      if ((a_q[31] ^ b_q[31]) || (b_q == '0)) div_lo = -quo;
      if (a_q[31]) div_hi = -rem;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (op_is_div(bus.mdu_op)) begin
            state_d = StDiv;
          end else begin
            state_d = StMul;
            cnt_d   = LatInit;
          end
        end else if (!bus.flush) begin
          if (bus.mthilo == MTHILO_LO) lo_d = bus.rs_data;
          if (bus.mthilo == MTHILO_HI) hi_d = bus.rs_data;
        end
      end
      StMul: begin
        if (cnt_q <= 5'd1) begin
          {hi_d, lo_d} = mul_res;
          state_d      = StIdle;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      StDiv: begin
        if (div_done) begin
          hi_d    = div_hi;
          lo_d    = div_lo;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= MDU_DUM;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      if (start) begin
        a_q  <= bus.rs_data;
        b_q  <= bus.rt_data;
        op_q <= bus.mdu_op;
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.hilo_out = (bus.mfhilo == MFHILO_HI) ? hi_q :
                        (bus.mfhilo == MFHILO_LO) ? lo_q : 32'h0;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: table of op vectors plus hand sequences for flush/reset corners.
module tb_mdu_hilo;
  import mdu_hilo_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mdu_hilo_if bus ();

  mdu_hilo #(.MULT_LAT(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs, rt, pre_hi, pre_lo, exp_hi, exp_lo;
    int          cycles;
  } vec_t;

  vec_t vecs[12];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic read_hilo(input logic [1:0] sel, output logic [31:0] v);
    bus.mfhilo = sel;
    #1 v = bus.hilo_out;
    bus.mfhilo = MFHILO_NONE;
  endtask

  task automatic check_hilo(input string name, input logic [31:0] hi, input logic [31:0] lo);
    logic [31:0] v;
    read_hilo(MFHILO_HI, v);
    check({name, " hi"}, v, hi);
    read_hilo(MFHILO_LO, v);
    check({name, " lo"}, v, lo);
  endtask

  // Called at a negedge; drives for one cycle and returns at the next negedge.
  task automatic drive(input logic [3:0] op, input logic [1:0] mth, input logic [31:0] rs,
                       input logic [31:0] rt, input logic fl);
    bus.mdu_op = op; bus.mthilo = mth; bus.rs_data = rs; bus.rt_data = rt; bus.flush = fl;
    @(negedge clk);
    bus.mdu_op = MDU_DUM; bus.mthilo = MTHILO_NONE; bus.flush = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (bus.busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        output int cycles);
    drive(op, MTHILO_NONE, rs, rt, 1'b0);
    wait_idle(cycles);
  endtask

  initial begin
    logic [31:0] v;
    int cyc;

    vecs[0]  = '{MDU_MULT,  32'hFFFFFFFE, 32'h3,        0, 0,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{MDU_MADDU, 32'hFFFFFFFF, 32'h2,        0, 32'h10,   32'h2,        32'hE,        5};
    vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h2,        0, 0,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[3]  = '{MDU_DIVU,  32'd100,      32'h0,        0, 0,        32'd100,      32'hFFFFFFFF, 33};
    vecs[4]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 0, 0,        32'h0,        32'h80000000, 33};
    vecs[5]  = '{MDU_DIV,   32'd7,        32'h0,        0, 0,        32'd7,        32'h1,        33};
    vecs[6]  = '{MDU_MSUB,  32'd3,        32'hFFFFFFFF, 0, 0,        32'h0,        32'h3,        5};
    vecs[7]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0,        32'hFFFFFFFE, 32'h1,        5};
    vecs[8]  = '{MDU_MADD,  32'd1,        32'd1,        0, 32'hFFFFFFFF, 32'h1,    32'h0,        5};
    vecs[9]  = '{MDU_MSUBU, 32'd1,        32'd1,        0, 0,        32'hFFFFFFFF, 32'hFFFFFFFF, 5};
    vecs[10] = '{MDU_DIVU,  32'd9,        32'd4,        0, 0,        32'd1,        32'd2,        33};
    vecs[11] = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 0, 0,        32'd1,        32'hFFFFFFFD, 33};

    bus.mdu_op = MDU_DUM; bus.mthilo = MTHILO_NONE; bus.mfhilo = MFHILO_NONE;
    bus.rs_data = '0; bus.rt_data = '0; bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    check("reset busy", {31'b0, bus.busy}, 32'h0);
    check_hilo("reset", 32'h0, 32'h0);
    read_hilo(MFHILO_NONE, v);
    check("mfhilo none", v, 32'h0);

    foreach (vecs[i]) begin
      drive(MDU_DUM, MTHILO_HI, vecs[i].pre_hi, 32'h0, 1'b0);
      drive(MDU_DUM, MTHILO_LO, vecs[i].pre_lo, 32'h0, 1'b0);
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, cyc);
      check($sformatf("v%0d busy cycles", i), 32'(cyc), 32'(vecs[i].cycles));
      check_hilo($sformatf("v%0d", i), vecs[i].exp_hi, vecs[i].exp_lo);
    end

    // Flush suppresses start and MTHI; illegal op and mthilo=10 do nothing.
    drive(MDU_DUM, MTHILO_HI, 32'h11, 32'h0, 1'b0);
    drive(MDU_DUM, MTHILO_LO, 32'h22, 32'h0, 1'b0);
    drive(MDU_MULT, MTHILO_NONE, 32'd2, 32'd3, 1'b1);
    check("flush mult busy", {31'b0, bus.busy}, 32'h0);
    drive(MDU_DUM, MTHILO_HI, 32'h55, 32'h0, 1'b1);
    drive(MDU_DUM, 2'b10, 32'h66, 32'h0, 1'b0);
    drive(4'd9, MTHILO_NONE, 32'd2, 32'd3, 1'b0);
    check("illegal op busy", {31'b0, bus.busy}, 32'h0);
    check_hilo("flush/illegal", 32'h11, 32'h22);

    // Start wins over a same-cycle MTLO: MADDU accumulates onto the old LO=0.
    drive(MDU_DUM, MTHILO_HI, 32'h0, 32'h0, 1'b0);
    drive(MDU_DUM, MTHILO_LO, 32'h0, 32'h0, 1'b0);
    drive(MDU_MADDU, MTHILO_LO, 32'd2, 32'd3, 1'b0);
    wait_idle(cyc);
    check_hilo("start over mtlo", 32'h0, 32'h6);

    // Inputs presented while busy are ignored.
    drive(MDU_MULT, MTHILO_NONE, 32'hFFFFFFFE, 32'd3, 1'b0);
    drive(MDU_DIVU, MTHILO_HI, 32'h99, 32'h1, 1'b0);
    drive(MDU_DUM, MTHILO_LO, 32'h98, 32'h1, 1'b0);
    wait_idle(cyc);
    check("busy-ignore cycles", 32'(cyc + 2), 32'd5);
    @(negedge clk);
    check("busy-ignore no restart", {31'b0, bus.busy}, 32'h0);
    check_hilo("busy-ignore", 32'hFFFFFFFF, 32'hFFFFFFFA);

    // Asynchronous reset in the middle of a divide.
    drive(MDU_DIV, MTHILO_NONE, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    check("mid-div busy before reset", {31'b0, bus.busy}, 32'h1);
    #2 reset_n = 1'b0;
    #1 check("mid-div reset busy", {31'b0, bus.busy}, 32'h0);
    check_hilo("mid-div reset", 32'h0, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_op(MDU_DIVU, 32'd9, 32'd4, cyc);
    check("post-reset divu cycles", 32'(cyc), 32'd33);
    check_hilo("post-reset divu", 32'd1, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
